ball_trajectory: RTL
====================

// Module: ball_trajectory
// PURPOSE
//  Upstream feeder of pixel_Gen. Produces ball_x/ball_y for the basketball shot.
//  Integrates a launched shot once per video frame: fixed-point position, velocity
//  and constant gravity. Detects a hoop score or a miss, holds the result on screen,
//  then re-arms at the start position.
//  frame_tick comes from the vga_sync domain; it is one pulse per frame, in vertical
//  blanking, so coordinates never change mid-frame.
// PARAMETERS
//  FRAC        4    fractional bits of position/velocity (Q.4, 1/16 px)
//  START_X     10   rest/launch x (px)
//  START_Y     300  rest/launch y (px, y grows downward)
//  GRAV        2    gravity added to vel_y per frame (1/16 px/frame^2)
//  VY_MAX      127  vel_y saturation, +/- (1/16 px/frame)
//  HOOP_X_MIN  560  hoop opening left edge (px, inclusive)
//  HOOP_X_MAX  600  hoop opening right edge (px, inclusive)
//  HOOP_Y      200  rim height (px)
//  FLOOR_Y     470  floor line (px); y >= FLOOR_Y is a miss
//  SCREEN_W    640  x >= SCREEN_W or x < 0 is a miss
//  HOLD_FRAMES 60   frames the RESULT state is held before re-arm
// PORTS
//  CLK25MHZ    in   1   pixel clock
//  reset       in   1   async, active-high
//  frame_tick  in   1   1-cycle pulse per frame, during vertical blanking
//  shoot       in   1   1-cycle launch request (debounced upstream)
//  vel_x0      in   8   signed Q4.4 launch x velocity (px/frame)
//  vel_y0      in   8   signed Q4.4 launch y velocity (negative = up)
//  ball_x      out  10  ball x (px), clamped to 0..SCREEN_W-1
//  ball_y      out  10  ball y (px), clamped to 0..479
//  in_flight   out  1   high in FLIGHT
//  score_pulse out  1   1-cycle pulse on score
//  miss_pulse  out  1   1-cycle pulse on miss
//  state       out  2   IDLE=0, FLIGHT=1, RESULT=2
// BEHAVIOUR
//  Reset values:
//  - All outputs: ball_x=START_X, ball_y=START_Y, in_flight=0, pulses=0, state=IDLE.
//  - Internals: pos=START<<FRAC, vel=0, hold counter=0.
//  Internal widths:
//  - pos_x/pos_y: signed 16b Q11.4.
//  - vel_x: signed 12b; vel_y: signed 12b, saturated to +/-VY_MAX.
//  - Velocity inputs are sign-extended.
//  IDLE:
//  - shoot latches vel_x0/vel_y0 and moves to FLIGHT on the next edge.
//  - frame_tick does nothing in IDLE.
//  - shoot with frame_tick in the same cycle: shoot wins; no integration that frame.
//  FLIGHT, on each frame_tick:
//  - pos_x += vel_x; pos_y += vel_y (old velocity).
//  - Then vel_y = sat(vel_y + GRAV).
//  - Evaluate new position:
//    - score: prev_y < HOOP_Y <= new_y AND HOOP_X_MIN <= new_x <= HOOP_X_MAX.
//    - miss: new_y >= FLOOR_Y OR new_x >= SCREEN_W OR new_x < 0.
//    - score and miss in the same frame: score wins.
//    - Either result: pulse 1 cycle, go to RESULT, clear the hold counter.
//  - shoot is ignored outside IDLE.
//  RESULT:
//  - Ball frozen at last position.
//  - hold counter increments per frame_tick.
//  - At HOLD_FRAMES: pos=START, vel=0, state goes to IDLE.
//  Timing:
//  - ball_x/ball_y/state/pulses are registered.
//  - They update exactly 1 clk after the frame_tick (or shoot) edge and are stable
//    for the rest of the frame.
//  Output conversion:
//  - Output = pos>>FRAC (integer part, floor).
//  - Negative values clamp to 0; values over range clamp to max.
//  - Clamping is output-only; internal pos is not clamped.
//  Async reset mid-flight: immediate return to reset values; no pulse is emitted.
// STRUCTURE
//  Package ball_pkg:
//  - state enum (IDLE/FLIGHT/RESULT).
//  - FRAC, POS_W=16, VEL_W=12, SCREEN_H=480.
//  Sub-module ball_axis_step, instantiated x and y:
//  - Combinational pos+vel add.
//  - Optional accel add with +/-limit saturation.
//  - Integer extraction with clamp.
//  The FSM, hold counter and hit detection live in ball_trajectory.
// TESTING
//  1 Reset, no stimulus
//    -> ball_x=10, ball_y=300, state=0; unchanged across 5 frame_ticks.
//  2 shoot with vel_x0=16 (1.0px), vel_y0=0, then frame_ticks
//    -> x=11,12,13; y=300,300,300.
//    -> Updates exactly 1 clk after each tick.
//  3 shoot with vel=0, default params
//    -> y offset after n ticks = n(n-1)/16 px.
//    -> miss_pulse on tick 53 (y>=470), not on 52.
//    -> After 60 more ticks: state=IDLE, ball at (10,300).
//  4 Overrides START_X=570, HOOP_Y=310; shoot with vel=0
//    -> score_pulse on tick 14, no miss_pulse, RESULT held 60 ticks.
//  5 shoot and frame_tick in the same cycle
//    -> no motion that frame.
//    -> shoot pulses during FLIGHT/RESULT are ignored (velocity unchanged).
//  6 reset asserted mid-flight (tick 20)
//    -> outputs return to reset values asynchronously; no score/miss pulse.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared types and fixed-point constants for the ball trajectory block.
// Positions are signed Q11.4 and velocities are signed Q7.4.
package ball_pkg;

  localparam int FRAC     = 4;
  localparam int POS_W    = 16;
  localparam int VEL_W    = 12;
  localparam int PIX_W    = 10;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Convert a whole-pixel coordinate to the internal fixed-point position format.
  function automatic logic signed [POS_W-1:0] to_fixed(input int px);
    return POS_W'(px <<< FRAC);
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One axis of ball motion: next position/velocity selection (re-arm, launch, integrate)
// and conversion of the next position to a clamped whole-pixel coordinate.
module ball_axis_step
  import ball_pkg::*;
#(
  parameter int ACCEL   = 0,
  parameter int V_LIMIT = 2047,
  parameter int PIX_MAX = 639
) (
  input  logic signed [POS_W-1:0] i_pos,
  input  logic signed [VEL_W-1:0] i_vel,
  input  logic                    i_step,
  input  logic                    i_launch,
  input  logic signed [VEL_W-1:0] i_launch_vel,
  input  logic                    i_rearm,
  input  logic signed [POS_W-1:0] i_start_pos,
  output logic signed [POS_W-1:0] o_pos_next,
  output logic signed [VEL_W-1:0] o_vel_next,
  output logic        [PIX_W-1:0] o_pix_next
);

  localparam int VS_W      = VEL_W + 1;
  localparam int PIX_INT_W = POS_W - FRAC;

  localparam logic signed [VS_W-1:0]      ACC_E     = VS_W'(ACCEL);
  localparam logic signed [VS_W-1:0]      LIM_P     = VS_W'(V_LIMIT);
  localparam logic signed [VS_W-1:0]      LIM_N     = VS_W'(-V_LIMIT);
  localparam logic signed [PIX_INT_W-1:0] PIX_MAX_S = PIX_INT_W'(PIX_MAX);
  localparam logic        [PIX_W-1:0]     PIX_MAX_U = PIX_W'(PIX_MAX);

  logic signed [POS_W-1:0]     w_vel_ext;
  logic signed [POS_W-1:0]     w_pos_sum;
  logic signed [VS_W-1:0]      w_vel_sum;
  logic signed [VEL_W-1:0]     w_vel_sat;
  logic signed [PIX_INT_W-1:0] w_pix_int;

  // The position integrates with the pre-update velocity; acceleration lands afterwards.
  assign w_vel_ext = {{(POS_W-VEL_W){i_vel[VEL_W-1]}}, i_vel};
  assign w_pos_sum = i_pos + w_vel_ext;
  assign w_vel_sum = {i_vel[VEL_W-1], i_vel} + ACC_E;

  always_comb begin
    w_vel_sat = w_vel_sum[VEL_W-1:0];
    if (w_vel_sum > LIM_P) begin
      w_vel_sat = LIM_P[VEL_W-1:0];
    end else if (w_vel_sum < LIM_N) begin
      w_vel_sat = LIM_N[VEL_W-1:0];
    end
  end

  always_comb begin
    o_pos_next = i_pos;
    o_vel_next = i_vel;
    if (i_rearm) begin
      o_pos_next = i_start_pos;
      o_vel_next = '0;
    end else if (i_launch) begin
      o_vel_next = i_launch_vel;
    end else if (i_step) begin
      o_pos_next = w_pos_sum;
      o_vel_next = w_vel_sat;
    end
  end

  // Floor to whole pixels, then clamp only the displayed value.
  assign w_pix_int = o_pos_next[POS_W-1:FRAC];

  always_comb begin
    o_pix_next = w_pix_int[PIX_W-1:0];
    if (w_pix_int[PIX_INT_W-1]) begin
      o_pix_next = '0;
    end else if (w_pix_int > PIX_MAX_S) begin
      o_pix_next = PIX_MAX_U;
    end
  end

endmodule

// File: rtl/ball_trajectory.sv
// Basketball shot integrator: launches on shoot, steps once per frame_tick under gravity,
// detects score/miss, holds the result for HOLD_FRAMES frames and re-arms at the start.
module ball_trajectory
  import ball_pkg::*;
#(
  parameter int START_X     = 10,
  parameter int START_Y     = 300,
  parameter int GRAV        = 2,
  parameter int VY_MAX      = 127,
  parameter int HOOP_X_MIN  = 560,
  parameter int HOOP_X_MAX  = 600,
  parameter int HOOP_Y      = 200,
  parameter int FLOOR_Y     = 470,
  parameter int SCREEN_W    = 640,
  parameter int HOLD_FRAMES = 60
) (
  input  logic              CLK25MHZ,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              shoot,
  input  logic signed [7:0] vel_x0,
  input  logic signed [7:0] vel_y0,
  output logic [PIX_W-1:0]  ball_x,
  output logic [PIX_W-1:0]  ball_y,
  output logic              in_flight,
  output logic              score_pulse,
  output logic              miss_pulse,
  output logic [1:0]        state
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  localparam logic signed [POS_W-1:0] START_X_FX = to_fixed(START_X);
  localparam logic signed [POS_W-1:0] START_Y_FX = to_fixed(START_Y);
  localparam logic signed [POS_W-1:0] HOOP_Y_FX  = to_fixed(HOOP_Y);
  localparam logic signed [POS_W-1:0] HX_MIN_FX  = to_fixed(HOOP_X_MIN);
  localparam logic signed [POS_W-1:0] HX_MAX_FX  = to_fixed(HOOP_X_MAX);
  localparam logic signed [POS_W-1:0] FLOOR_FX   = to_fixed(FLOOR_Y);
  localparam logic signed [POS_W-1:0] SCREEN_FX  = to_fixed(SCREEN_W);

  state_t                  r_state, w_state_next;
  logic signed [POS_W-1:0] r_pos_x, r_pos_y;
  logic signed [VEL_W-1:0] r_vel_x, r_vel_y;
  logic [HOLD_W-1:0]       r_hold, w_hold_next;
  logic [PIX_W-1:0]        r_ball_x, r_ball_y;
  logic                    r_in_flight, r_score, r_miss;

  logic                    w_launch, w_step, w_rearm;
  logic                    w_score, w_miss, w_hit_score, w_hit_miss;
  logic signed [POS_W-1:0] w_pos_x_next, w_pos_y_next;
  logic signed [VEL_W-1:0] w_vel_x_next, w_vel_y_next;
  logic signed [VEL_W-1:0] w_launch_vx, w_launch_vy;
  logic [PIX_W-1:0]        w_pix_x_next, w_pix_y_next;

  // Shoot takes priority over a same-cycle tick because integration only runs in FLIGHT.
  assign w_launch    = (r_state == IDLE) && shoot;
  assign w_step      = (r_state == FLIGHT) && frame_tick;
  assign w_rearm     = (r_state == RESULT) && frame_tick && (r_hold == HOLD_LAST);
  assign w_launch_vx = {{(VEL_W-8){vel_x0[7]}}, vel_x0};
  assign w_launch_vy = {{(VEL_W-8){vel_y0[7]}}, vel_y0};

  ball_axis_step #(
    .ACCEL   (0),
    .V_LIMIT ((1 << (VEL_W-1)) - 1),
    .PIX_MAX (SCREEN_W - 1)
  ) u_axis_x (
    .i_pos        (r_pos_x),
    .i_vel        (r_vel_x),
    .i_step       (w_step),
    .i_launch     (w_launch),
    .i_launch_vel (w_launch_vx),
    .i_rearm      (w_rearm),
    .i_start_pos  (START_X_FX),
    .o_pos_next   (w_pos_x_next),
    .o_vel_next   (w_vel_x_next),
    .o_pix_next   (w_pix_x_next)
  );

  ball_axis_step #(
    .ACCEL   (GRAV),
    .V_LIMIT (VY_MAX),
    .PIX_MAX (SCREEN_H - 1)
  ) u_axis_y (
    .i_pos        (r_pos_y),
    .i_vel        (r_vel_y),
    .i_step       (w_step),
    .i_launch     (w_launch),
    .i_launch_vel (w_launch_vy),
    .i_rearm      (w_rearm),
    .i_start_pos  (START_Y_FX),
    .o_pos_next   (w_pos_y_next),
    .o_vel_next   (w_vel_y_next),
    .o_pix_next   (w_pix_y_next)
  );

  // Score means the ball crossed rim height downward this frame inside the hoop opening.
  assign w_hit_score = (r_pos_y < HOOP_Y_FX) && (w_pos_y_next >= HOOP_Y_FX) &&
                       (w_pos_x_next >= HX_MIN_FX) && (w_pos_x_next <= HX_MAX_FX);
  assign w_hit_miss  = (w_pos_y_next >= FLOOR_FX) || (w_pos_x_next >= SCREEN_FX) ||
                       w_pos_x_next[POS_W-1];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_score      = 1'b0;
    w_miss       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_launch) w_state_next = FLIGHT;
      end
      FLIGHT: begin
        if (w_step && w_hit_score) begin
          w_score      = 1'b1;
          w_state_next = RESULT;
          w_hold_next  = '0;
        end else if (w_step && w_hit_miss) begin
          w_miss       = 1'b1;
          w_state_next = RESULT;
          w_hold_next  = '0;
        end
      end
      RESULT: begin
        if (w_rearm) begin
          w_state_next = IDLE;
          w_hold_next  = '0;
        end else if (frame_tick) begin
          w_hold_next = r_hold + HOLD_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK25MHZ or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pos_x     <= START_X_FX;
      r_pos_y     <= START_Y_FX;
      r_vel_x     <= '0;
      r_vel_y     <= '0;
      r_hold      <= '0;
      r_ball_x    <= PIX_W'(START_X);
      r_ball_y    <= PIX_W'(START_Y);
      r_in_flight <= 1'b0;
      r_score     <= 1'b0;
      r_miss      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pos_x     <= w_pos_x_next;
      r_pos_y     <= w_pos_y_next;
      r_vel_x     <= w_vel_x_next;
      r_vel_y     <= w_vel_y_next;
      r_hold      <= w_hold_next;
      r_ball_x    <= w_pix_x_next;
      r_ball_y    <= w_pix_y_next;
      r_in_flight <= (w_state_next == FLIGHT);
      r_score     <= w_score;
      r_miss      <= w_miss;
    end
  end

  assign ball_x      = r_ball_x;
  assign ball_y      = r_ball_y;
  assign in_flight   = r_in_flight;
  assign score_pulse = r_score;
  assign miss_pulse  = r_miss;
  assign state       = r_state;

endmodule
